// File: rtl/regfile_wb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
// The write-stage struct is sized by the default widths used by the top.
package regfile_wb_pkg;

    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_MAX_WAIT      = 4;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_ALU  = 2'd1,
        REQ_LSU  = 2'd2
    } req_sel_e;

    typedef struct packed {
        logic                         valid;
        logic [DEF_ADDRESS_WIDTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0]    data;
    } wb_stage_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, register 0 never busy.
// A set and a clear of the same register on one edge leaves it busy.
module regfile_scoreboard
    import regfile_wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_set_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_set_rd,
    input  logic                     i_clr_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_clr_rd,
    input  logic [ADDRESS_WIDTH-1:0] i_rs1,
    input  logic [ADDRESS_WIDTH-1:0] i_rs2,
    output logic                     o_busy1,
    output logic                     o_busy2
);

    localparam int NREG = 1 << ADDRESS_WIDTH;

    logic [NREG-1:1] r_busy;
    logic [NREG-1:0] w_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (i_set_valid && (i_set_rd == ADDRESS_WIDTH'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (i_clr_valid && (i_clr_rd == ADDRESS_WIDTH'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign w_busy  = {r_busy, 1'b0};
    assign o_busy1 = w_busy[i_rs1];
    assign o_busy2 = w_busy[i_rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ALU/LSU writeback arbiter with a one-entry write stage and busy scoreboard.
// Define REGFILE_WB_BYPASS_EN to forward the write-stage value to decode.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MAX_WAIT      = DEF_MAX_WAIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    output logic                     alu_ready,
    input  logic                     lsu_valid,
    input  logic [ADDRESS_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     lsu_ready,
    input  logic                     alloc_valid,
    input  logic [ADDRESS_WIDTH-1:0] alloc_rd,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    output logic                     busy1,
    output logic                     busy2,
    output logic                     byp1_valid,
    output logic                     byp2_valid,
    output logic [DATA_WIDTH-1:0]    byp_data,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic                     WE3,
    output logic [DATA_WIDTH-1:0]    WD3
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    // Handshake: a request transfers on any cycle where valid and ready are
    // both high; ready depends only on the valids and the wait counter.
    req_sel_e                 w_sel;
    logic [ADDRESS_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0]    w_data;
    logic                     w_load;
    logic                     w_busy1;
    logic                     w_busy2;
    logic [WAIT_W-1:0]        r_wait_cnt;
    wb_stage_t                r_ws;

    always_comb begin
        w_sel = REQ_NONE;
        if (rst_n) begin
            if (alu_valid && (!lsu_valid || (r_wait_cnt == WAIT_MAX))) begin
                w_sel = REQ_ALU;
            end else if (lsu_valid) begin
                w_sel = REQ_LSU;
            end
        end
    end

    assign alu_ready = (w_sel == REQ_ALU);
    assign lsu_ready = (w_sel == REQ_LSU);
    assign w_rd      = (w_sel == REQ_ALU) ? alu_rd   : lsu_rd;
    assign w_data    = (w_sel == REQ_ALU) ? alu_data : lsu_data;
    // Writes to register 0 are accepted but never reach the write port.
    assign w_load    = (w_sel != REQ_NONE) && (w_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (alu_valid && (w_sel == REQ_LSU)) begin
            if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Address and data only move on a real write so they hold while WE3 is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ws <= '0;
        end else begin
            r_ws.valid <= w_load;
            if (w_load) begin
                r_ws.rd   <= w_rd;
                r_ws.data <= w_data;
            end
        end
    end

    assign WE3 = r_ws.valid;
    assign AD3 = r_ws.rd;
    assign WD3 = r_ws.data;

    regfile_scoreboard #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_scoreboard (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_set_valid(alloc_valid),
        .i_set_rd   (alloc_rd),
        .i_clr_valid(WE3),
        .i_clr_rd   (AD3),
        .i_rs1      (rs1),
        .i_rs2      (rs2),
        .o_busy1    (w_busy1),
        .o_busy2    (w_busy2)
    );

`ifdef REGFILE_WB_BYPASS_EN
    assign byp1_valid = WE3 && (AD3 == rs1) && (rs1 != '0);
    assign byp2_valid = WE3 && (AD3 == rs2) && (rs2 != '0);
    assign byp_data   = WD3;
    assign busy1      = w_busy1 && !byp1_valid;
    assign busy2      = w_busy2 && !byp2_valid;
`else
    assign byp1_valid = 1'b0;
    assign byp2_valid = 1'b0;
    assign byp_data   = '0;
    assign busy1      = w_busy1;
    assign busy2      = w_busy2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the writeback rules.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MW = 4;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          lsu_valid = 1'b0;
    logic [AW-1:0] lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          lsu_ready;
    logic          alloc_valid = 1'b0;
    logic [AW-1:0] alloc_rd = '0;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic          busy1, busy2, byp1_valid, byp2_valid;
    logic [DW-1:0] byp_data;
    logic [AW-1:0] AD3;
    logic          WE3;
    logic [DW-1:0] WD3;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit [31:0]     m_busy;
    int            m_wait;
    bit            m_we;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;
    bit            last_ga, last_gl;

    regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2),
        .byp1_valid(byp1_valid), .byp2_valid(byp2_valid), .byp_data(byp_data),
        .AD3(AD3), .WE3(WE3), .WD3(WD3)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_wait = 0;
        m_we   = 1'b0;
        m_ad   = '0;
        m_wd   = '0;
    endtask

    function automatic void model_grant(output bit ga, output bit gl);
        ga = 1'b0;
        gl = 1'b0;
        if (alu_valid && lsu_valid) begin
            if (m_wait == MW) ga = 1'b1;
            else gl = 1'b1;
        end else if (alu_valid) begin
            ga = 1'b1;
        end else if (lsu_valid) begin
            gl = 1'b1;
        end
    endfunction

    // One clock: check combinational outputs, advance model at the edge,
    // then check the write port.
    task automatic step();
        bit            ga, gl, e_p1, e_p2, e_b1, e_b2;
        logic [DW-1:0] e_bd;
        logic [AW-1:0] g_rd;
        logic [DW-1:0] g_data;
        #1;
        model_grant(ga, gl);
        e_b1 = m_busy[rs1];
        e_b2 = m_busy[rs2];
        e_p1 = BYP && m_we && (m_ad == rs1) && (rs1 != 0);
        e_p2 = BYP && m_we && (m_ad == rs2) && (rs2 != 0);
        e_b1 = e_b1 && !e_p1;
        e_b2 = e_b2 && !e_p2;
        e_bd = BYP ? m_wd : '0;
        chk("alu_ready", alu_ready, ga);
        chk("lsu_ready", lsu_ready, gl);
        chk("busy1", busy1, e_b1);
        chk("busy2", busy2, e_b2);
        chk("byp1_valid", byp1_valid, e_p1);
        chk("byp2_valid", byp2_valid, e_p2);
        chk("byp_data", byp_data, e_bd);
        last_ga = ga;
        last_gl = gl;
        @(posedge clk);
        if (m_we) m_busy[m_ad] = 1'b0;
        if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
        if (alu_valid && gl) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        else m_wait = 0;
        if (ga || gl) begin
            g_rd   = ga ? alu_rd : lsu_rd;
            g_data = ga ? alu_data : lsu_data;
            m_we   = (g_rd != 0);
            if (m_we) begin
                m_ad = g_rd;
                m_wd = g_data;
            end
        end else begin
            m_we = 1'b0;
        end
        #1;
        chk("WE3", WE3, m_we);
        chk("AD3", AD3, m_ad);
        chk("WD3", WD3, m_wd);
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        alloc_valid = 1'b0;
    endtask

    // Both requesters valid for six cycles; expect LSU x4, ALU, LSU.
    task automatic contend_six(input string tag);
        bit [5:0] exp_alu = 6'b010000;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hA1A1_0000;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hB2B2_0000;
        for (int c = 0; c < 6; c++) begin
            alu_data = alu_data + 1;
            lsu_data = lsu_data + 1;
            step();
            chk({tag, "_alu_grant"}, last_ga, exp_alu[c]);
            chk({tag, "_lsu_grant"}, last_gl, !exp_alu[c]);
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_WE3", WE3, 1'b0);
        chk("rst_AD3", AD3, '0);
        chk("rst_WD3", WD3, '0);
        chk("rst_alu_ready", alu_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Scenario 1: single ALU write, one-cycle latency.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        chk("s1_alu_ready", last_ga, 1'b1);
        chk("s1_WE3", WE3, 1'b1);
        chk("s1_AD3", AD3, 5'd5);
        chk("s1_WD3", WD3, 32'hDEADBEEF);
        idle_inputs();
        step();

        // Scenario 2: continuous contention.
        contend_six("s2");
        step();

        // Scenario 3: alloc then write three cycles later.
        alloc_valid = 1'b1; alloc_rd = 5'd7; rs1 = 5'd7;
        step();
        alloc_valid = 1'b0;
        chk("s3_busy_set", busy1, 1'b1);
        step();
        step();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hCAFE_0007;
        step();
        lsu_valid = 1'b0;
        chk("s3_busy_we_cycle", busy1, !BYP);
        chk("s3_byp1_we_cycle", byp1_valid, BYP);
        step();
        chk("s3_busy_cleared", busy1, 1'b0);

        // Scenario 4: write to register 0 is accepted and dropped.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        step();
        alu_valid = 1'b0;
        chk("s4_alu_ready", last_ga, 1'b1);
        chk("s4_WE3", WE3, 1'b0);
        chk("s4_AD3_hold", AD3, 5'd7);
        rs1 = 5'd0;
        #1 chk("s4_busy0", busy1, 1'b0);

        // Scenario 5: alloc and clear of register 9 on the same edge.
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        step();
        alloc_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0909_0909;
        step();
        alu_valid = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        chk("s5_WE3_ad9", {WE3, AD3}, {1'b1, 5'd9});
        step();
        alloc_valid = 1'b0;
        rs1 = 5'd9;
        #1 chk("s5_busy9_kept", busy1, 1'b1);

        // Scenario 6: reset while the write stage holds rd=3.
        alloc_valid = 1'b1; alloc_rd = 5'd3;
        step();
        alloc_valid = 1'b0;
        rs1 = 5'd3; rs2 = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h3333;
        repeat (3) step();
        chk("s6_pre_WE3_ad3", {WE3, AD3}, {1'b1, 5'd3});
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("s6_rst_WE3", WE3, 1'b0);
        chk("s6_rst_AD3", AD3, '0);
        chk("s6_rst_WD3", WD3, '0);
        chk("s6_rst_alu_ready", alu_ready, 1'b0);
        chk("s6_rst_lsu_ready", lsu_ready, 1'b0);
        chk("s6_rst_busy1", busy1, 1'b0);
        chk("s6_rst_busy2", busy2, 1'b0);
        @(posedge clk);
        #1;
        chk("s6_no_write", WE3, 1'b0);
        rst_n = 1'b1;
        idle_inputs();
        step();
        contend_six("s6");

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            alu_valid   = ($urandom_range(0, 1) == 1);
            alu_rd      = AW'($urandom_range(0, 15));
            alu_data    = $urandom;
            lsu_valid   = ($urandom_range(0, 2) != 0);
            lsu_rd      = AW'($urandom_range(0, 15));
            lsu_data    = $urandom;
            alloc_valid = ($urandom_range(0, 2) == 0);
            alloc_rd    = AW'($urandom_range(0, 15));
            rs1         = AW'($urandom_range(0, 15));
            rs2         = AW'($urandom_range(0, 15));
            step();
        end
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
